// File: rtl/audio_pkg.sv
// Shared audio constants: default sample width, bit-clock divider, LRCLK channel codes.
package audio_pkg;
  localparam int   AUDIO_WIDTH    = 16;
  localparam int   AUDIO_BCLK_DIV = 4;
  localparam logic LR_LEFT        = 1'b0;
  localparam logic LR_RIGHT       = 1'b1;
endpackage

// File: rtl/bclk_gen.sv
// Bit-clock generator: divides the system clock into BCLK and flags the last
// system cycle of each BCLK period (the cycle before BCLK falls).
module bclk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = AUDIO_BCLK_DIV
) (
  input  logic clk_in,
  input  logic reset,
  output logic bclk,
  output logic fall_tick
);

  localparam int           CW   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BCLK_DIV / 2);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          fall_tick_q, fall_tick_d;

  // Next divider count; bclk and the fall strobe are decoded from it so they line up with the count.
  always_comb begin
    div_cnt_d   = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    bclk_d      = (div_cnt_d >= HALF);
    fall_tick_d = (div_cnt_d == LAST);
  end

  // Divider state, cleared to the start of a low BCLK half on reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      fall_tick_q <= fall_tick_d;
    end
  end

  assign bclk      = bclk_q;
  assign fall_tick = fall_tick_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-slot holding register on a valid/ready input,
// frame loader with bypass/underrun handling, and an MSB-first {L,R} serializer.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int WIDTH    = AUDIO_WIDTH,
  parameter int BCLK_DIV = AUDIO_BCLK_DIV
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int            FW       = 2 * WIDTH;
  localparam int            BW       = $clog2(FW);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
  localparam logic [BW-1:0] R_START  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] R_END    = BW'(FW - 2);

  logic          fall_tick;
  logic          accept, frame_load;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [FW-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          underrun_q, underrun_d;

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk_in    (clk_in),
    .reset     (reset),
    .bclk      (bclk),
    .fall_tick (fall_tick)
  );

  assign accept     = sample_valid && !hold_full_q;
  assign frame_load = fall_tick && (bit_cnt_q == LAST_BIT);

  // Handshake, framing and serializer next-state; a frame load overrides the plain shift.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;

    if (accept) begin
      hold_d      = {sample_l, sample_r};
      hold_full_d = 1'b1;
    end

    if (fall_tick) begin
      bit_cnt_d = frame_load ? '0 : bit_cnt_q + 1'b1;
      shift_d   = {shift_q[FW-2:0], 1'b0};
    end

    if (frame_load) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else if (sample_valid) begin
        // Bypass: the pair goes straight to the shifter and never occupies the hold.
        shift_d     = {sample_l, sample_r};
        hold_full_d = 1'b0;
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // LRCLK switches one bit ahead of each channel's MSB.
    lrclk_d = ((bit_cnt_d >= R_START) && (bit_cnt_d <= R_END)) ? LR_RIGHT : LR_LEFT;
    sdata_d = shift_d[FW-1];
  end

  // Control and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bit_cnt_q   <= LAST_BIT;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      lrclk_q     <= LR_LEFT;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  // Holding-register payload; only meaningful while hold_full_q is set.
  always_ff @(posedge clk_in) begin
    hold_q <= hold_d;
  end

  assign sample_ready = !hold_full_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: frame-level reference model of the I2S stream plus directed checks.
module tb_i2s_tx;

  localparam int W     = 16;
  localparam int DIV   = 4;
  localparam int FRAME = 2 * W * DIV;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic [W-1:0]  sample_l = '0;
  logic [W-1:0]  sample_r = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready, bclk, lrclk, sdata, underrun;

  i2s_tx #(.WIDTH(W), .BCLK_DIV(DIV)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Reference model: t = cycles since reset release; frames = words loaded at each frame start.
  int             t = 0;
  bit             m_hold_full = 1'b0;
  logic [2*W-1:0] m_hold = '0;
  logic [2*W-1:0] m_frames[$];
  bit             m_und = 1'b0;
  int             ucount = 0;
  int             acount = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  // Bit slot within the stream: slot 0 starts the cycle after the first frame-load fall.
  function automatic int bit_pos(input int tt);
    return ((tt - DIV) / DIV) % (2 * W);
  endfunction

  function automatic logic exp_sdata(input int tt);
    int f;
    if (tt < DIV) return 1'b0;
    f = (tt - DIV) / FRAME;
    if (f >= m_frames.size()) return 1'b0;
    return m_frames[f][2*W-1-bit_pos(tt)];
  endfunction

  function automatic logic exp_lrclk(input int tt);
    int p;
    if (tt < DIV) return 1'b0;
    p = bit_pos(tt);
    return (p >= W - 1) && (p <= 2 * W - 2);
  endfunction

  // Drive one cycle of inputs, check all outputs for this cycle, advance model and clock.
  task automatic run_cycle(input bit v, input logic [W-1:0] l, input logic [W-1:0] r);
    sample_valid = v;
    sample_l     = l;
    sample_r     = r;
    chk("bclk",     bclk,         logic'((t % DIV) >= DIV / 2));
    chk("lrclk",    lrclk,        exp_lrclk(t));
    chk("sdata",    sdata,        exp_sdata(t));
    chk("ready",    sample_ready, logic'(!m_hold_full));
    chk("underrun", underrun,     logic'(m_und));
    if (underrun === 1'b1) ucount++;
    if (v && sample_ready === 1'b1) acount++;
    m_und = 1'b0;
    if ((t % FRAME) == DIV - 1) begin
      if (m_hold_full) begin
        m_frames.push_back(m_hold);
        m_hold_full = 1'b0;
      end else if (v) begin
        m_frames.push_back({l, r});
      end else begin
        m_frames.push_back('0);
        m_und = 1'b1;
      end
    end else if (v && !m_hold_full) begin
      m_hold      = {l, r};
      m_hold_full = 1'b1;
    end
    @(posedge clk_in);
    #1;
    t++;
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk_in);
      #1;
      chk("rst_bclk",     bclk,         1'b0);
      chk("rst_lrclk",    lrclk,        1'b0);
      chk("rst_sdata",    sdata,        1'b0);
      chk("rst_ready",    sample_ready, 1'b1);
      chk("rst_underrun", underrun,     1'b0);
    end
    reset       = 1'b0;
    t           = 0;
    m_hold_full = 1'b0;
    m_und       = 1'b0;
    m_frames.delete();
  endtask

  initial begin
    logic [31:0]  cap;
    logic [W-1:0] cnt;
    logic [W-1:0] rl, rr;
    bit           acc;

    // Reset state
    do_reset(5);

    // Single frame followed by two underrun frames
    cap = '0;
    run_cycle(1'b1, 16'hA5C3, 16'h0F01);
    ucount = 0;
    while (t < 2 * FRAME + DIV + 1) begin
      if (t >= DIV && t < DIV + FRAME && (t % DIV) == DIV / 2) cap = {cap[30:0], sdata};
      run_cycle(1'b0, '0, '0);
    end
    chk_int("frame_bits", int'(cap), int'(32'hA5C30F01));
    chk_int("underrun_pulses", ucount, 2);

    // Bypass: valid only in the load cycle with the hold empty
    while (t < 3 * FRAME + DIV - 1) run_cycle(1'b0, '0, '0);
    ucount = 0;
    run_cycle(1'b1, 16'h8001, 16'h7FFE);
    while (t < 4 * FRAME + DIV - 1) run_cycle(1'b0, '0, '0);
    chk_int("bypass_no_underrun", ucount, 0);

    // Back-pressure: valid held high with an incrementing pair
    cnt = 16'(32'h1234 + $urandom_range(0, 255));
    while (t < 4 * FRAME + DIV + 1) begin
      acc = !m_hold_full;
      run_cycle(1'b1, cnt, ~cnt);
      if (acc) cnt++;
    end
    acount = 0;
    while (t < 8 * FRAME + DIV - 1) begin
      acc = !m_hold_full;
      run_cycle(1'b1, cnt, ~cnt);
      if (acc) cnt++;
    end
    chk_int("accepts_per_frame", acount, 3);

    // Random valid and data
    while (t < 11 * FRAME) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      run_cycle(($urandom_range(0, 7) == 0), rl, rr);
    end

    // Mid-frame reset at bit 10, then a fresh pair after release
    do_reset(2);
    run_cycle(1'b1, 16'hDEAD, 16'hBEEF);
    while (t < DIV + 10 * DIV) run_cycle(1'b0, '0, '0);
    do_reset(3);
    run_cycle(1'b1, 16'h5A5A, 16'hC3C3);
    cap = '0;
    while (t < FRAME + 2 * DIV) begin
      if (t >= DIV && t < DIV + FRAME && (t % DIV) == DIV / 2) cap = {cap[30:0], sdata};
      run_cycle(1'b0, '0, '0);
    end
    chk_int("post_reset_bits", int'(cap), int'(32'h5A5AC3C3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
